// File: rtl/counter_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// counter_sweep_ctrl
//
// Control side of a universal up/down binary counter. On start it loads
// start_val into the counter, then sweeps q up, down or triangularly to
// stop_val. A shadow copy of the expected count (r_exp) is checked against the
// counter's q / max_tick / min_tick feedback on every RUN cycle; any
// disagreement ends the sweep with err and aborted set.
//
// Ports
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous, active-low reset
//   start      in   1      1-cycle sweep request, sampled only in IDLE
//   mode       in   2      00 up-once, 01 down-once, 10 triangle-once,
//                          11 triangle-continuous
//   start_val  in   N      value loaded into the counter at sweep start
//   stop_val   in   N      sweep end point (turn point in triangle modes)
//   abort      in   1      terminate any active sweep
//   q          in   N      counter output
//   max_tick   in   1      counter at all-ones
//   min_tick   in   1      counter at zero
//   syn_clr    out  1      counter synchronous clear (asserted in FIN)
//   load       out  1      counter parallel load (asserted in LOAD)
//   en         out  1      counter count enable (combinational on q/abort)
//   up         out  1      counter direction, 1 = up
//   d          out  N      counter load data
//   busy       out  1      high in every state except IDLE
//   done       out  1      1-cycle pulse on entry to FIN
//   aborted    out  1      high with done when the sweep ended early
//   err        out  1      sticky mismatch flag, cleared by reset or start
//   sweep_cnt  out  CNT_W  completed sweeps since the last start
// -----------------------------------------------------------------------------
module counter_sweep_ctrl #(
  parameter int N     = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [N-1:0]     start_val,
  input  logic [N-1:0]     stop_val,
  input  logic             abort,
  input  logic [N-1:0]     q,
  input  logic             max_tick,
  input  logic             min_tick,
  output logic             syn_clr,
  output logic             load,
  output logic             en,
  output logic             up,
  output logic [N-1:0]     d,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             err,
  output logic [CNT_W-1:0] sweep_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN_UP,
    S_RUN_DN,
    S_FIN
  } state_t;

  typedef enum logic [1:0] {
    M_UP       = 2'b00,
    M_DOWN     = 2'b01,
    M_TRI      = 2'b10,
    M_TRI_CONT = 2'b11
  } mode_t;

  state_t           r_state;
  state_t           w_state_nxt;
  mode_t            r_mode;
  logic [N-1:0]     r_start_val;
  logic [N-1:0]     r_stop_val;
  logic [N-1:0]     r_exp;
  logic             r_err;
  logic [CNT_W-1:0] r_sweep_cnt;
  logic             r_syn_clr;
  logic             r_load;
  logic             r_up;
  logic [N-1:0]     r_d;
  logic             r_busy;
  logic             r_done;
  logic             r_aborted;

  logic             w_accept;
  logic             w_cfg_bad;
  logic [N-1:0]     w_end_dn;
  logic             w_en;
  logic             w_check_fail;
  logic             w_set_err;
  logic             w_fin_aborted;
  logic             w_sweep_inc;

  // Start is only honoured in IDLE; a request while busy is dropped.
  assign w_accept = (r_state == S_IDLE) && start;

  // Direction-dependent sanity check on the incoming (not yet latched) config.
  assign w_cfg_bad = (mode == M_DOWN) ? (stop_val > start_val)
                                      : (stop_val < start_val);

  // Down-sweeps end at stop_val for down-once, but return to start_val when
  // they are the falling half of a triangle.
  assign w_end_dn = (r_mode == M_DOWN) ? r_stop_val : r_start_val;

  // ---------------------------------------------------------------------------
  // Next-state and combinational control
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path through
    // this block leaves one unassigned, which would infer a latch.
    w_state_nxt   = r_state;
    w_en          = 1'b0;
    w_check_fail  = 1'b0;
    w_set_err     = 1'b0;
    w_fin_aborted = 1'b0;
    w_sweep_inc   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_cfg_bad) begin
            w_state_nxt   = S_FIN;
            w_set_err     = 1'b1;
            w_fin_aborted = 1'b1;
          end else begin
            w_state_nxt = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        w_state_nxt = (r_mode == M_DOWN) ? S_RUN_DN : S_RUN_UP;
      end

      S_RUN_UP: begin
        w_en         = (q != r_stop_val);
        // max_tick anywhere but the end point means the counter wrapped.
        w_check_fail = (q != r_exp) || (max_tick && (q != r_stop_val));
        if (!w_en) begin
          if (r_mode == M_UP) begin
            w_state_nxt = S_FIN;
            w_sweep_inc = 1'b1;
          end else begin
            w_state_nxt = S_RUN_DN;
          end
        end
      end

      S_RUN_DN: begin
        w_en         = (q != w_end_dn);
        w_check_fail = (q != r_exp) || (min_tick && (q != w_end_dn));
        if (!w_en) begin
          w_sweep_inc = 1'b1;
          // Continuous triangle turns straight back up without reloading.
          w_state_nxt = (r_mode == M_TRI_CONT) ? S_RUN_UP : S_FIN;
        end
      end

      S_FIN: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // A feedback mismatch ends the sweep as a failure.
    if (w_check_fail) begin
      w_state_nxt   = S_FIN;
      w_set_err     = 1'b1;
      w_fin_aborted = 1'b1;
      w_sweep_inc   = 1'b0;
    end

    // abort outranks everything in the active states, and it must stop the
    // counter in the same cycle, hence the combinational gating of en.
    if (abort && (r_state inside {S_LOAD, S_RUN_UP, S_RUN_DN})) begin
      w_en          = 1'b0;
      w_state_nxt   = S_FIN;
      w_set_err     = 1'b0;
      w_fin_aborted = 1'b1;
      w_sweep_inc   = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State, shadow model and sweep bookkeeping
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values and ordering between blocks cannot matter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_mode      <= M_UP;
      r_start_val <= '0;
      r_stop_val  <= '0;
      r_exp       <= '0;
      r_err       <= 1'b0;
      r_sweep_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_accept) begin
        r_mode      <= mode_t'(mode);
        r_start_val <= start_val;
        r_stop_val  <= stop_val;
      end

      // The shadow count follows exactly the enable actually driven out.
      if (r_state == S_LOAD) begin
        r_exp <= r_start_val;
      end else if ((r_state == S_RUN_UP) && w_en) begin
        r_exp <= r_exp + N'(1);
      end else if ((r_state == S_RUN_DN) && w_en) begin
        r_exp <= r_exp - N'(1);
      end

      // A new start clears err unless the new config is itself rejected.
      if (w_accept) begin
        r_err <= w_set_err;
      end else if (w_set_err) begin
        r_err <= 1'b1;
      end

      if (w_accept) begin
        r_sweep_cnt <= '0;
      end else if (w_sweep_inc) begin
        r_sweep_cnt <= r_sweep_cnt + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs, decoded from the state being entered so each one is
  // valid for exactly the cycles spent in that state.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_syn_clr <= 1'b0;
      r_load    <= 1'b0;
      r_up      <= 1'b0;
      r_d       <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_syn_clr <= (w_state_nxt == S_FIN);
      r_load    <= (w_state_nxt == S_LOAD);
      r_up      <= (w_state_nxt == S_RUN_UP);
      r_busy    <= (w_state_nxt != S_IDLE);
      r_done    <= (w_state_nxt == S_FIN);
      r_aborted <= (w_state_nxt == S_FIN) && w_fin_aborted;
      if (w_accept) begin
        r_d <= start_val;
      end
    end
  end

  assign syn_clr   = r_syn_clr;
  assign load      = r_load;
  assign en        = w_en;
  assign up        = r_up;
  assign d         = r_d;
  assign busy      = r_busy;
  assign done      = r_done;
  assign aborted   = r_aborted;
  assign err       = r_err;
  assign sweep_cnt = r_sweep_cnt;

endmodule
